// File: rtl/pwg_pkg.sv
// Shared types and helpers for the period wave generator.
// The FSM state encoding is visible on the block's state output.
package pwg_pkg;

   localparam int PW_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } state_t;

   // Computed with one spare bit so that P = all-ones rounds up without wrapping.
   function automatic logic [31:0] half_up(input logic [31:0] p);
      logic [32:0] s;
      s = {1'b0, p} + 33'd1;
      return s[32:1];
   endfunction

endpackage

// File: rtl/persist_filter.sv
// Counts consecutive cycles of i_lvl, saturating at N.
// o_hit is a lookahead: it is high on the cycle where the count reaches N at this edge.
module persist_filter #(
   parameter int N = 3
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_lvl,
   output logic o_hit
);

   localparam int CW = $clog2(N + 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clr || !i_lvl)
         r_cnt <= '0;
      else if (r_cnt != CW'(N))
         r_cnt <= r_cnt + CW'(1);
   end

   // The level seen at this edge completes the run, so the FSM can react on the same edge.
   assign o_hit = i_lvl && (r_cnt >= CW'(N - 1));

endmodule

// File: rtl/period_wave_generator.sv
// Square-wave generator on clk_ex with a period taken from the clock monitor.
// The output is forced low while the monitor reports the clock as failing.
module period_wave_generator
   import pwg_pkg::*;
#(
   parameter int PW        = PW_DEF,
   parameter int FAIL_FILT = 3,
   parameter int RECOV_CYC = 8
) (
   input  logic          clk_ex,
   input  logic          rst,
   input  logic          enable,
   input  logic [PW-1:0] period_in,
   input  logic          fail_in,
   output logic          wave_out,
   output logic          period_tick,
   output logic [PW-1:0] active_period,
   output logic          fault,
   output logic [1:0]    state_o
);

   state_t        r_state, w_state_nxt;
   logic [PW-1:0] r_cnt, w_cnt_nxt;
   logic [PW-1:0] r_ap, w_ap_nxt;
   logic [PW-1:0] r_hi, w_hi_nxt;
   logic          w_fail_hit, w_recov_hit, w_last;
   logic [PW-1:0] w_hi_in;

   persist_filter #(.N(FAIL_FILT)) u_fail_filt (
      .i_clk (clk_ex),
      .i_rst (rst),
      .i_clr (1'b0),
      .i_lvl (fail_in),
      .o_hit (w_fail_hit)
   );

   // Recovery only counts while in FAULT, so it starts fresh on each entry.
   persist_filter #(.N(RECOV_CYC)) u_recov_filt (
      .i_clk (clk_ex),
      .i_rst (rst),
      .i_clr (r_state != FAULT),
      .i_lvl (~fail_in),
      .o_hit (w_recov_hit)
   );

   assign w_hi_in = PW'(half_up(32'(period_in)));
   assign w_last  = (r_cnt == r_ap - PW'(1));

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ap_nxt    = r_ap;
      w_hi_nxt    = r_hi;
      if (w_fail_hit) begin
         w_state_nxt = FAULT;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            FAULT: begin
               if (w_recov_hit)
                  w_state_nxt = IDLE;
            end
            IDLE: begin
               if (enable && (period_in != '0)) begin
                  w_state_nxt = RUN;
                  w_ap_nxt    = period_in;
                  w_hi_nxt    = w_hi_in;
                  w_cnt_nxt   = '0;
               end
            end
            RUN: begin
               if (!enable || (r_ap == '0)) begin
                  w_state_nxt = IDLE;
                  w_cnt_nxt   = '0;
               end else if (w_last) begin
                  // New period is only adopted at the wrap, so no period is ever torn.
                  w_cnt_nxt = '0;
                  if (period_in != '0) begin
                     w_ap_nxt = period_in;
                     w_hi_nxt = w_hi_in;
                  end else begin
                     w_state_nxt = IDLE;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + PW'(1);
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_ex) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_ap    <= '0;
         r_hi    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ap    <= w_ap_nxt;
         r_hi    <= w_hi_nxt;
      end
   end

   assign wave_out      = (r_state == RUN) && (r_cnt < r_hi);
   assign period_tick   = (r_state == RUN) && w_last;
   assign active_period = r_ap;
   assign fault         = (r_state == FAULT);
   assign state_o       = r_state;

endmodule

// File: tb/tb_period_wave_generator.sv
// Bench for period_wave_generator: reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_period_wave_generator;

   localparam int FAIL_FILT = 3;
   localparam int RECOV_CYC = 8;

   logic       clk_ex = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] period_in = 8'd0;
   logic       fail_in = 1'b0;
   logic       wave_out, period_tick, fault;
   logic [7:0] active_period;
   logic [1:0] state_o;

   int checks = 0;
   int errors = 0;

   period_wave_generator #(.PW(8), .FAIL_FILT(FAIL_FILT), .RECOV_CYC(RECOV_CYC)) dut (
      .clk_ex        (clk_ex),
      .rst           (rst),
      .enable        (enable),
      .period_in     (period_in),
      .fail_in       (fail_in),
      .wave_out      (wave_out),
      .period_tick   (period_tick),
      .active_period (active_period),
      .fault         (fault),
      .state_o       (state_o)
   );

   always #5 clk_ex = ~clk_ex;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: state as 0 idle / 1 running / 2 fault, position in period,
   // current period, and run lengths of fail_in high and of fail_in low while faulted.
   int m_st = 0, m_pos = 0, m_per = 0, m_hirun = 0, m_lorun = 0;
   bit m_vld = 0;

   task automatic model_step();
      int p;
      p = int'(period_in);
      if (rst) begin
         m_st = 0; m_pos = 0; m_per = 0; m_hirun = 0; m_lorun = 0;
      end else begin
         m_hirun = fail_in ? ((m_hirun < FAIL_FILT) ? m_hirun + 1 : m_hirun) : 0;
         m_lorun = (m_st == 2 && !fail_in) ? m_lorun + 1 : 0;
         if (m_hirun == FAIL_FILT) begin
            m_st = 2; m_pos = 0;
         end else if (m_st == 2) begin
            if (m_lorun >= RECOV_CYC) begin m_st = 0; m_lorun = 0; end
         end else if (m_st == 0) begin
            if (enable && p != 0) begin m_st = 1; m_per = p; m_pos = 0; end
         end else begin
            if (!enable || m_per == 0) begin
               m_st = 0; m_pos = 0;
            end else if (m_pos + 1 == m_per) begin
               m_pos = 0;
               if (p != 0) m_per = p;
               else m_st = 0;
            end else begin
               m_pos++;
            end
         end
      end
      m_vld = 1;
   endtask

   initial forever begin
      @(posedge clk_ex);
      model_step();
   end

   always @(negedge clk_ex) begin
      if (m_vld) begin
         chk("wave_out", wave_out, (m_st == 1 && m_pos < (m_per + 1) / 2) ? 1 : 0);
         chk("period_tick", period_tick, (m_st == 1 && m_pos == m_per - 1) ? 1 : 0);
         chk("active_period", active_period, m_per);
         chk("fault", fault, (m_st == 2) ? 1 : 0);
         chk("state_o", state_o, m_st);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_ex);
   endtask

   task automatic wait_ap(input int v, input string nm);
      bit hit;
      hit = 0;
      for (int i = 0; i < 40 && !hit; i++) begin
         @(negedge clk_ex);
         if (active_period == 8'(v)) hit = 1;
      end
      chk(nm, hit, 1);
   endtask

   initial begin
      int highs, ticks, tickpos, burst;

      // 1: reset with enable already up
      enable = 1'b1; period_in = 8'd6; rst = 1'b1;
      repeat (3) begin
         @(negedge clk_ex);
         chk("rst_wave", wave_out, 0);
         chk("rst_state", state_o, 0);
         chk("rst_ap", active_period, 0);
      end
      rst = 1'b0;
      highs = 0; tickpos = -1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_ex);
         if (i < 3) chk("p6_high", wave_out, 1);
         else       chk("p6_low", wave_out, 0);
         highs += int'(wave_out);
         if (period_tick) tickpos = i;
      end
      chk("p6_highs", highs, 3);
      chk("p6_tickpos", tickpos, 5);

      // 2: period change mid-period lands at the wrap
      cyc(3);
      period_in = 8'd10;
      repeat (3) begin
         @(negedge clk_ex);
         chk("ap_hold6", active_period, 6);
      end
      @(negedge clk_ex);
      chk("ap_new10", active_period, 10);
      highs = int'(wave_out);
      repeat (9) begin @(negedge clk_ex); highs += int'(wave_out); end
      chk("p10_highs", highs, 5);

      // 3: extremes
      period_in = 8'd1;
      wait_ap(1, "wait_p1");
      repeat (4) begin
         @(negedge clk_ex);
         chk("p1_wave", wave_out, 1);
         chk("p1_tick", period_tick, 1);
      end
      period_in = 8'd255;
      wait_ap(255, "wait_p255");
      highs = int'(wave_out); ticks = int'(period_tick);
      repeat (254) begin
         @(negedge clk_ex);
         highs += int'(wave_out); ticks += int'(period_tick);
      end
      chk("p255_highs", highs, 128);
      chk("p255_ticks", ticks, 1);
      chk("p255_lastcyc_tick", period_tick, 1);

      // 4: fail filter and recovery
      fail_in = 1'b1; cyc(2);
      chk("fail2_nofault", fault, 0);
      fail_in = 1'b0; cyc(1);
      fail_in = 1'b1; cyc(2);
      chk("fail2b_nofault", fault, 0);
      cyc(1);
      chk("fail3_fault", fault, 1);
      chk("fail3_wave", wave_out, 0);
      fail_in = 1'b0; cyc(7);
      chk("recov7_state", state_o, 2);
      cyc(1);
      chk("recov8_idle", state_o, 0);
      cyc(1);
      chk("recov_run", state_o, 1);

      // 5: enable ignored in FAULT, recovery restarts on a fail pulse
      fail_in = 1'b1; cyc(3);
      chk("refault", state_o, 2);
      fail_in = 1'b0; enable = 1'b0; cyc(2);
      enable = 1'b1; cyc(2);
      chk("fault_en_ignored", state_o, 2);
      fail_in = 1'b1; cyc(1);
      fail_in = 1'b0; enable = 1'b0; cyc(7);
      chk("recov_restart", state_o, 2);
      cyc(1);
      chk("recov_restart_idle", state_o, 0);
      enable = 1'b1; cyc(1);
      chk("restart_run", state_o, 1);

      // 6: abort mid-high, then no start with zero period
      cyc(2);
      chk("mid_high", wave_out, 1);
      enable = 1'b0; cyc(1);
      chk("abort_state", state_o, 0);
      chk("abort_wave", wave_out, 0);
      period_in = 8'd0; enable = 1'b1;
      repeat (5) begin
         @(negedge clk_ex);
         chk("p0_idle", state_o, 0);
      end

      // Randomized traffic; the per-cycle model check covers it
      burst = 0;
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 599) == 0);
         enable = ($urandom_range(0, 99) < 96);
         if ($urandom_range(0, 99) < 8) begin
            case ($urandom_range(0, 5))
               0:       period_in = 8'd0;
               1:       period_in = 8'd255;
               2:       period_in = 8'd1;
               default: period_in = 8'($urandom_range(2, 14));
            endcase
         end
         if (burst > 0) begin
            fail_in = 1'b1; burst--;
         end else if ($urandom_range(0, 99) < 3) begin
            fail_in = 1'b1; burst = $urandom_range(0, 4);
         end else begin
            fail_in = 1'b0;
         end
         @(negedge clk_ex);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
